// File: rtl/seven_segment_scan_driver_pkg.sv
// seven_segment_scan_driver_pkg: shared segment encodings and display constants
package seven_segment_scan_driver_pkg;
   // Segment vectors are {g,f,e,d,c,b,a}, active-low
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic       ANODE_OFF = 1'b1;
   localparam logic       PHASE_ON  = 1'b0;
   localparam logic       PHASE_OFF = 1'b1;
endpackage

// File: rtl/seven_segment_scan_driver_bcd_to_seven_segment.sv
// bcd_to_seven_segment: BCD digit to active-low segments, blank for 10-15
module bcd_to_seven_segment
   import seven_segment_scan_driver_pkg::*;
(
   input  logic [3:0] i_Bcd,
   output logic [6:0] o_Segments
);
   // Pure lookup; non-decimal codes show nothing
   always_comb begin
      case (i_Bcd)
         4'd0:    o_Segments = SEG_0;
         4'd1:    o_Segments = SEG_1;
         4'd2:    o_Segments = SEG_2;
         4'd3:    o_Segments = SEG_3;
         4'd4:    o_Segments = SEG_4;
         4'd5:    o_Segments = SEG_5;
         4'd6:    o_Segments = SEG_6;
         4'd7:    o_Segments = SEG_7;
         4'd8:    o_Segments = SEG_8;
         4'd9:    o_Segments = SEG_9;
         default: o_Segments = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed common-anode display scanner with PM dot, leading-zero blank and blink
module seven_segment_scan_driver
   import seven_segment_scan_driver_pkg::*;
#(
   parameter int DECIMAL_DIGITS     = 4,
   parameter int CLKS_PER_DIGIT     = 100000,
   parameter int PM_DIGIT           = 0,
   parameter int LEADING_ZERO_BLANK = 1,
   parameter int BLINK_FRAMES       = 250
) (
   input  logic                        i_Clk,
   input  logic                        i_Reset,
   input  logic [4*DECIMAL_DIGITS-1:0] i_Display_Time,
   input  logic                        i_Display_PM,
   input  logic                        i_Blink,
   output logic [DECIMAL_DIGITS-1:0]   o_Anode,
   output logic [6:0]                  o_Segments,
   output logic                        o_DP
);
   localparam int PW = $clog2(CLKS_PER_DIGIT);
   localparam int IW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [IW-1:0] LAST_DIGIT = IW'(DECIMAL_DIGITS - 1);
   logic [PW-1:0]               presc_q, presc_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [4*DECIMAL_DIGITS-1:0] time_q, time_d;
   logic                        pm_q, pm_d;
   logic [FW-1:0]               frame_q, frame_d;
   logic                        phase_q, phase_d;
   logic [DECIMAL_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]                  seg_q, seg_d;
   logic                        dp_q, dp_d;
   logic                        tick, frame_start, frame_wrap, lead_zero;
   logic [3:0]                  nibble;
   logic [6:0]                  dec_seg;
   bcd_to_seven_segment u_dec (
      .i_Bcd      (nibble),
      .o_Segments (dec_seg)
   );
   // Next state: outputs are built from the post-tick index and the snapshot/phase that frame will use
   always_comb begin
      tick        = presc_q == PW'(CLKS_PER_DIGIT - 1);
      frame_start = tick && idx_q == LAST_DIGIT;
      frame_wrap  = frame_q == FW'(BLINK_FRAMES - 1);
      presc_d     = tick ? '0 : presc_q + PW'(1);
      idx_d       = !tick ? idx_q : (idx_q == LAST_DIGIT) ? '0 : idx_q + IW'(1);
      time_d      = frame_start ? i_Display_Time : time_q;
      pm_d        = frame_start ? i_Display_PM : pm_q;
      frame_d     = !i_Blink ? '0 : !frame_start ? frame_q : frame_wrap ? '0 : frame_q + FW'(1);
      phase_d     = !i_Blink ? PHASE_ON : (frame_start && frame_wrap) ? ~phase_q : phase_q;
      nibble      = time_d[{idx_d, 2'b00} +: 4];
      lead_zero   = LEADING_ZERO_BLANK != 0 && idx_d == LAST_DIGIT && nibble == 4'd0;
      anode_d     = !tick ? anode_q
                  : (i_Blink && phase_d == PHASE_OFF) ? {DECIMAL_DIGITS{ANODE_OFF}}
                  : ~(DECIMAL_DIGITS'(1) << idx_d);
      seg_d       = !tick ? seg_q : lead_zero ? SEG_BLANK : dec_seg;
      dp_d        = !tick ? dp_q : !(idx_d == IW'(PM_DIGIT) && pm_d);
   end
   // State and output registers, cleared asynchronously
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         presc_q <= '0;
         idx_q   <= LAST_DIGIT;
         time_q  <= '0;
         pm_q    <= 1'b0;
         frame_q <= '0;
         phase_q <= PHASE_ON;
         anode_q <= {DECIMAL_DIGITS{ANODE_OFF}};
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         time_q  <= time_d;
         pm_q    <= pm_d;
         frame_q <= frame_d;
         phase_q <= phase_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end
   assign o_Anode    = anode_q;
   assign o_Segments = seg_q;
   assign o_DP       = dp_q;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb_seven_segment_scan_driver: directed and random checks against a cycle-count reference model
module tb_seven_segment_scan_driver;
   localparam int ND  = 4;
   localparam int CPD = 4;
   localparam int PMD = 0;
   localparam int BF  = 2;
   logic        i_Clk = 1'b0;
   logic        i_Reset;
   logic [15:0] i_Display_Time;
   logic        i_Display_PM;
   logic        i_Blink;
   logic [3:0]  o_Anode;
   logic [6:0]  o_Segments;
   logic        o_DP;
   int checks = 0;
   int errors = 0;
   seven_segment_scan_driver #(
      .DECIMAL_DIGITS     (ND),
      .CLKS_PER_DIGIT     (CPD),
      .PM_DIGIT           (PMD),
      .LEADING_ZERO_BLANK (1),
      .BLINK_FRAMES       (BF)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Reset        (i_Reset),
      .i_Display_Time (i_Display_Time),
      .i_Display_PM   (i_Display_PM),
      .i_Blink        (i_Blink),
      .o_Anode        (o_Anode),
      .o_Segments     (o_Segments),
      .o_DP           (o_DP)
   );
   always #5 i_Clk = ~i_Clk;
   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction
   // Reference: n counts cycles since reset release; every CPD-th cycle lights digit (n/CPD-1)%ND.
   // Blink phase is OFF when the number of frame starts seen while blinking, divided by BF, is odd.
   int          n, starts;
   logic [15:0] m_time;
   logic        m_pm;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   always @(posedge i_Clk or posedge i_Reset) begin
      int dig;
      logic [3:0] nib;
      if (i_Reset) begin
         n = 0; starts = 0; m_time = '0; m_pm = 1'b0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         n++;
         if (!i_Blink) starts = 0;
         if (n % CPD == 0) begin
            dig = (n / CPD - 1) % ND;
            if (dig == 0) begin
               m_time = i_Display_Time;
               m_pm   = i_Display_PM;
               if (i_Blink) starts++;
            end
            nib   = m_time[dig*4 +: 4];
            e_an  = (i_Blink && (starts / BF) % 2 == 1) ? 4'hF : ~(4'b0001 << dig);
            e_seg = (dig == ND - 1 && nib == 4'd0) ? 7'h7F : seg_of(nib);
            e_dp  = !(dig == PMD && m_pm);
         end
      end
   end
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic dp);
      chk({tag, "_anode"}, 16'(o_Anode), 16'(an));
      chk({tag, "_seg"}, 16'(o_Segments), 16'(sg));
      chk({tag, "_dp"}, 16'(o_DP), 16'(dp));
   endtask
   task automatic run_chk(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge i_Clk);
         chk_out(tag, e_an, e_seg, e_dp);
      end
   endtask
   initial begin
      i_Reset = 1'b1; i_Display_Time = 16'h0; i_Display_PM = 1'b0; i_Blink = 1'b0;
      repeat (2) @(negedge i_Clk);
      chk_out("reset", 4'hF, 7'h7F, 1'b1);
      i_Reset = 1'b0; i_Display_Time = 16'h1234;
      repeat (3) @(negedge i_Clk);
      chk_out("pre_tick", 4'hF, 7'h7F, 1'b1);
      @(negedge i_Clk);
      chk_out("d0_first", 4'b1110, 7'h19, 1'b1);
      repeat (4) @(negedge i_Clk);
      chk_out("d1", 4'b1101, 7'h30, 1'b1);
      repeat (4) @(negedge i_Clk);
      chk_out("d2", 4'b1011, 7'h24, 1'b1);
      repeat (4) @(negedge i_Clk);
      chk_out("d3", 4'b0111, 7'h79, 1'b1);
      repeat (4) @(negedge i_Clk);
      chk_out("wrap_d0", 4'b1110, 7'h19, 1'b1);
      run_chk(32, "scan1234");
      i_Display_Time = 16'h0945; i_Display_PM = 1'b1;
      run_chk(16, "pm_pre");
      chk_out("pm_d0", 4'b1110, 7'h12, 1'b0);
      run_chk(12, "pm_scan");
      chk_out("lzb_d3", 4'b0111, 7'h7F, 1'b1);
      i_Display_Time = 16'h1234; i_Display_PM = 1'b0;
      run_chk(8, "tear_pre");
      i_Display_Time = 16'h5678;
      run_chk(8, "tear_mid");
      chk_out("tear_d3_old", 4'b0111, 7'h79, 1'b1);
      run_chk(4, "tear_new");
      chk_out("tear_d0_new", 4'b1110, 7'h00, 1'b1);
      i_Display_Time = 16'h12A4;
      run_chk(20, "hex_pre");
      chk_out("hex_d1", 4'b1101, 7'h7F, 1'b1);
      i_Blink = 1'b1;
      run_chk(160, "blink");
      i_Blink = 1'b0;
      run_chk(8, "unblink");
      for (int i = 0; i < 400; i++) begin
         @(negedge i_Clk);
         if ($urandom_range(0, 7) == 0) begin
            i_Display_Time = 16'($urandom);
            i_Display_PM   = 1'($urandom);
         end
         if ($urandom_range(0, 47) == 0) i_Blink = ~i_Blink;
         chk_out("random", e_an, e_seg, e_dp);
      end
      i_Blink = 1'b0; i_Display_Time = 16'h0321; i_Display_PM = 1'b1;
      repeat (6) @(negedge i_Clk);
      #2 i_Reset = 1'b1;
      #1 chk_out("async_rst", 4'hF, 7'h7F, 1'b1);
      @(negedge i_Clk);
      i_Reset = 1'b0;
      repeat (3) @(negedge i_Clk);
      chk_out("rst_hold", 4'hF, 7'h7F, 1'b1);
      @(negedge i_Clk);
      chk_out("rst_d0", 4'b1110, 7'h79, 1'b0);
      run_chk(40, "post_rst");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
